// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-word holding register for gap-free frames.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN (adds input brk).
module uart_tx_param #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_enb,
`ifdef UART_TX_BREAK_EN
    input  logic                 brk,
`endif
    output logic                 tx,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int SCW = $clog2(STOP_BITS + 1);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
    localparam logic [SCW-1:0] STOP_LAST = SCW'(STOP_BITS);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS=%0d outside 5..9", DATA_BITS);
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY_MODE=%0d outside 0..2", PARITY_MODE);
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("uart_tx_param: STOP_BITS=%0d outside 1..2", STOP_BITS);
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state_reg;
    logic                 tx_reg;
    logic                 ready_reg;
    logic                 done_reg;
    logic                 overrun_reg;
    logic                 brk_active_reg;
    logic                 par_reg;
    logic [DATA_BITS-1:0] hold_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [BCW-1:0]       bit_cnt_reg;
    logic [SCW-1:0]       stop_cnt_reg;
    logic                 break_req;

`ifdef UART_TX_BREAK_EN
    assign break_req = brk;
`else
    assign break_req = 1'b0;
`endif

    // Parity of the held word, seeded with 1 for odd parity so the chain end is the bit to send.
    logic [DATA_BITS:0] par_chain;
    assign par_chain[0] = (PARITY_MODE == 2);
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ hold_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            tx_reg         <= 1'b1;
            ready_reg      <= 1'b1;
            done_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
            brk_active_reg <= 1'b0;
            par_reg        <= 1'b0;
            hold_reg       <= '0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            stop_cnt_reg   <= '0;
        end else begin
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;

            // Acceptance looks only at the registered ready; a transfer this cycle cannot free the slot early.
            if (wr) begin
                if (ready_reg) begin
                    hold_reg  <= data_in;
                    ready_reg <= 1'b0;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    tx_reg         <= ~break_req;
                    brk_active_reg <= break_req;
                    if (!ready_reg && !break_req) begin
                        shift_reg <= hold_reg;
                        par_reg   <= par_chain[DATA_BITS];
                        ready_reg <= 1'b1;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (tx_enb) begin
                        tx_reg      <= 1'b0;
                        bit_cnt_reg <= '0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (tx_enb) begin
                        tx_reg    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            bit_cnt_reg  <= '0;
                            stop_cnt_reg <= '0;
                            state_reg    <= (PARITY_MODE != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BCW'(1);
                        end
                    end
                end
                PAR: begin
                    if (tx_enb) begin
                        tx_reg       <= par_reg;
                        stop_cnt_reg <= '0;
                        state_reg    <= STOP;
                    end
                end
                STOP: begin
                    if (tx_enb) begin
                        if (stop_cnt_reg == STOP_LAST) begin
                            // End-of-frame tick: chain straight into the next start bit when a word waits.
                            done_reg     <= 1'b1;
                            stop_cnt_reg <= '0;
                            if (!ready_reg && !break_req) begin
                                shift_reg   <= hold_reg;
                                par_reg     <= par_chain[DATA_BITS];
                                ready_reg   <= 1'b1;
                                tx_reg      <= 1'b0;
                                bit_cnt_reg <= '0;
                                state_reg   <= DATA;
                            end else begin
                                tx_reg         <= 1'b1;
                                brk_active_reg <= break_req;
                                state_reg      <= IDLE;
                            end
                        end else begin
                            tx_reg       <= 1'b1;
                            stop_cnt_reg <= stop_cnt_reg + SCW'(1);
                        end
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_reg;
    assign ready   = ready_reg;
    assign done    = done_reg;
    assign overrun = overrun_reg;
    assign busy    = (state_reg != IDLE) | ~ready_reg | brk_active_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: a default instance and a 7-bit / odd-parity / 2-stop instance.
module tb_uart_tx_param;

    localparam int DB0 = 8, PM0 = 0, SB0 = 1;
    localparam int DB1 = 7, PM1 = 2, SB1 = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_enb = 1'b0;
    logic       wr0 = 1'b0, wr1 = 1'b0;
    logic [7:0] din0 = '0;
    logic [6:0] din1 = '0;
    logic       tx0, ready0, busy0, done0, ovr0;
    logic       tx1, ready1, busy1, done1, ovr1;
`ifdef UART_TX_BREAK_EN
    logic       brk0 = 1'b0, brk1 = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    int  exp_q0[$];
    int  exp_q1[$];
    int  mon_phase[2], mon_idx[2], mon_word[2], mon_stop[2];
    int  mon_gap[2], last_gap[2], frames[2];
    bit  mon_en[2];
    int  done_cnt0 = 0, done_cnt1 = 0, ovr_cnt0 = 0;
    bit  tick_on = 1'b0;
    int  div = 0;

    uart_tx_param #(.DATA_BITS(DB0), .PARITY_MODE(PM0), .STOP_BITS(SB0)) dut0 (
        .clk(clk), .reset(reset), .wr(wr0), .data_in(din0), .tx_enb(tx_enb),
`ifdef UART_TX_BREAK_EN
        .brk(brk0),
`endif
        .tx(tx0), .ready(ready0), .busy(busy0), .done(done0), .overrun(ovr0)
    );

    uart_tx_param #(.DATA_BITS(DB1), .PARITY_MODE(PM1), .STOP_BITS(SB1)) dut1 (
        .clk(clk), .reset(reset), .wr(wr1), .data_in(din1), .tx_enb(tx_enb),
`ifdef UART_TX_BREAK_EN
        .brk(brk1),
`endif
        .tx(tx1), .ready(ready1), .busy(busy1), .done(done1), .overrun(ovr1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Baud tick: one clock wide, every 16 clocks while enabled.
    initial begin
        forever begin
            @(negedge clk);
            tx_enb = tick_on && (div == 15);
            div = (div + 1) % 16;
        end
    end

    always @(negedge clk) begin
        if (done0 === 1'b1) done_cnt0++;
        if (done1 === 1'b1) done_cnt1++;
        if (ovr0 === 1'b1) ovr_cnt0++;
    end

    task automatic mon_sample(input int m, input logic b);
        int db, pm, sb, exp_w, ones, qn;
        db = (m == 0) ? DB0 : DB1;
        pm = (m == 0) ? PM0 : PM1;
        sb = (m == 0) ? SB0 : SB1;
        case (mon_phase[m])
            0: begin
                if (b === 1'b0) begin
                    mon_phase[m] = 1;
                    mon_idx[m] = 0;
                    mon_word[m] = 0;
                    last_gap[m] = mon_gap[m];
                end else begin
                    mon_gap[m]++;
                end
            end
            1: begin
                if (b === 1'b1) mon_word[m] |= (1 << mon_idx[m]);
                mon_idx[m]++;
                if (mon_idx[m] == db) begin
                    mon_phase[m] = (pm != 0) ? 2 : 3;
                    mon_stop[m] = 0;
                end
            end
            2: begin
                ones = $countones(mon_word[m]);
                check($sformatf("parity_m%0d", m), b, (ones % 2) ^ ((pm == 2) ? 1 : 0));
                mon_phase[m] = 3;
            end
            default: begin
                check($sformatf("stop_bit_m%0d", m), b, 1);
                mon_stop[m]++;
                if (mon_stop[m] == sb) begin
                    qn = (m == 0) ? exp_q0.size() : exp_q1.size();
                    check($sformatf("frame_expected_m%0d", m), (qn > 0), 1);
                    if (qn > 0) begin
                        exp_w = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("word_m%0d", m), mon_word[m], exp_w);
                        $display("frame m%0d: word=0x%0h expected=0x%0h gap=%0d", m, mon_word[m], exp_w, last_gap[m]);
                    end
                    frames[m]++;
                    mon_phase[m] = 0;
                    mon_gap[m] = 0;
                end
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                mon_phase[m] = 0;
                mon_gap[m] = 0;
            end
        end else if (tx_enb) begin
            #1;
            if (mon_en[0]) mon_sample(0, tx0);
            if (mon_en[1]) mon_sample(1, tx1);
        end
    end

    task automatic write0(input logic [7:0] d, input bit accept);
        @(negedge clk);
        check("ready_at_wr0", ready0, accept);
        wr0 = 1'b1;
        din0 = d;
        if (accept) exp_q0.push_back(int'(d));
        $display("wr m0: data=0x%0h accept=%0d", d, accept);
        @(negedge clk);
        wr0 = 1'b0;
    endtask

    task automatic write1(input logic [6:0] d, input bit accept);
        @(negedge clk);
        check("ready_at_wr1", ready1, accept);
        wr1 = 1'b1;
        din1 = d;
        if (accept) exp_q1.push_back(int'(d));
        $display("wr m1: data=0x%0h accept=%0d", d, accept);
        @(negedge clk);
        wr1 = 1'b0;
    endtask

    task automatic wait_frames(input int m, input int target, input int budget);
        int n;
        n = 0;
        while (frames[m] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("frame_in_time_m%0d", m), (frames[m] >= target), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, ovb, n, hi_cnt;
        for (int m = 0; m < 2; m++) begin
            frames[m] = 0;
            mon_en[m] = 1'b1;
            last_gap[m] = 0;
        end

        // Reset state, sampled while reset is held
        repeat (3) @(negedge clk);
        check("rst_tx", tx0, 1);
        check("rst_ready", ready0, 1);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_overrun", ovr0, 0);
        reset = 1'b0;
        tick_on = 1'b1;

        // 1: single 0xA5 frame on the default instance
        write0(8'hA5, 1'b1);
        repeat (50) @(negedge clk);
        check("busy_mid_frame", busy0, 1);
        wait_frames(0, 1, 400);
        repeat (40) @(negedge clk);
        check("done_count_t1", done_cnt0, 1);
        check("busy_after_t1", busy0, 0);
        check("tx_idle_t1", tx0, 1);

        // 2: 7 data bits, odd parity, two stop bits
        write1(7'h41, 1'b1);
        wait_frames(1, 1, 500);
        repeat (40) @(negedge clk);
        check("done_count_t2", done_cnt1, 1);
        check("busy_after_t2", busy1, 0);

        // 3: second word written while the first frame is on the line
        base = frames[0];
        write0(8'h11, 1'b1);
        repeat (40) @(negedge clk);
        write0(8'h22, 1'b1);
        wait_frames(0, base + 2, 800);
        check("gap_b2b_t3", last_gap[0], 0);
        repeat (40) @(negedge clk);
        check("done_count_t3", done_cnt0, 3);

        // 4: no ticks, shift reg and holding reg full, third write overruns
        tick_on = 1'b0;
        repeat (20) @(negedge clk);
        base = frames[0];
        write0(8'h11, 1'b1);
        repeat (3) @(negedge clk);
        write0(8'h22, 1'b1);
        ovb = ovr_cnt0;
        write0(8'h33, 1'b0);
        repeat (3) @(negedge clk);
        check("overrun_once", ovr_cnt0 - ovb, 1);
        check("ready_full_t4", ready0, 0);
        check("busy_full_t4", busy0, 1);
        tick_on = 1'b1;
        wait_frames(0, base + 2, 800);
        check("gap_b2b_t4", last_gap[0], 0);
        repeat (16 * 14) @(negedge clk);
        check("frames_only_two_t4", frames[0] - base, 2);

        // 5: reset during the 4th data bit, with a word also waiting in holding
        write0(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        write0(8'h5A, 1'b1);
        n = 0;
        while (!(mon_phase[0] == 1 && mon_idx[0] == 4) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("reach_4th_bit", (n < 600), 1);
        base = frames[0];
        reset = 1'b1;
        #1;
        check("abort_tx", tx0, 1);
        check("abort_ready", ready0, 1);
        check("abort_busy", busy0, 0);
        void'(exp_q0.pop_front());
        void'(exp_q0.pop_front());
        repeat (2) @(negedge clk);
        reset = 1'b0;
        write0(8'h3C, 1'b1);
        wait_frames(0, base + 1, 600);
        repeat (16 * 14) @(negedge clk);
        check("frames_after_reset", frames[0] - base, 1);

`ifdef UART_TX_BREAK_EN
        // 6: break held for 40 ticks with a word pending
        mon_en[0] = 1'b0;
        @(negedge clk);
        brk0 = 1'b1;
        repeat (3) @(negedge clk);
        check("brk_tx_low", tx0, 0);
        check("brk_busy", busy0, 1);
        write0(8'h55, 1'b1);
        hi_cnt = 0;
        for (int i = 0; i < 40 * 16; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b0) hi_cnt++;
        end
        check("brk_low_throughout", hi_cnt, 0);
        base = frames[0];
        brk0 = 1'b0;
        mon_phase[0] = 0;
        mon_en[0] = 1'b1;
        wait_frames(0, base + 1, 600);
`else
        hi_cnt = 0;
`endif

        check("queue0_empty", exp_q0.size(), 0);
        check("queue1_empty", exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
